// File: rtl/txll_arb.sv
// rtl/txll_arb.sv - frame-atomic two-requester arbiter in front of a TX FIFO write port
//
// Arbitrates two 36-bit word streams onto one TX FIFO write port. Once a
// requester is granted it owns the port until the word carrying EOF (bit 34)
// is written. A new frame only starts while fewer than C_MAX_FRAMES complete
// frames are outstanding and the FIFO is not almost full.
//
// Optional build macro: TXLL_ARB_STRICT_PRIO_EN (src0 always wins a tie in IDLE);
// when undefined, ties are resolved round-robin.
//
// Ports:
//   wr_clk, rst                          clock, synchronous active-high reset
//   srcN_di/srcN_valid/srcN_ready        requester N word stream (N = 0, 1)
//   fifo_wr_di/fifo_wr_en                TX FIFO write port
//   fifo_wr_full/fifo_wr_almost_full     TX FIFO fill status
//   fifo_wr_eof_poped                    one pulse per EOF word popped (wr_clk domain)
//   grant                                one-hot current owner, 00 when idle
//   frames_out                           complete frames written, not yet popped
module txll_arb #(
  parameter int C_MAX_FRAMES = 8
) (
  input  logic        wr_clk,
  input  logic        rst,
  input  logic [35:0] src0_di,
  input  logic        src0_valid,
  output logic        src0_ready,
  input  logic [35:0] src1_di,
  input  logic        src1_valid,
  output logic        src1_ready,
  output logic [35:0] fifo_wr_di,
  output logic        fifo_wr_en,
  input  logic        fifo_wr_full,
  input  logic        fifo_wr_almost_full,
  input  logic        fifo_wr_eof_poped,
  output logic [1:0]  grant,
  output logic [3:0]  frames_out
);

  localparam logic [3:0] MAX_FRAMES = 4'(C_MAX_FRAMES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       last_grant_q, last_grant_d;  // 0 = src0 granted last, 1 = src1
  logic [3:0] frames_q, frames_d;

  logic wr0, wr1, eof_wr, can_start, pop_ok;

  // Outputs follow the state; reset forces them quiet even before the
  // reset edge has returned the FSM to IDLE, so an abandoned frame writes nothing.
  always_comb begin
    grant      = 2'b00;
    src0_ready = 1'b0;
    src1_ready = 1'b0;
    if (!rst) begin
      grant      = {state_q == GNT1, state_q == GNT0};
      src0_ready = (state_q == GNT0) && !fifo_wr_full;
      src1_ready = (state_q == GNT1) && !fifo_wr_full;
    end
  end

  assign wr0        = src0_valid & src0_ready;
  assign wr1        = src1_valid & src1_ready;
  assign fifo_wr_en = wr0 | wr1;
  assign fifo_wr_di = wr0 ? src0_di : (wr1 ? src1_di : 36'd0);
  assign eof_wr     = fifo_wr_en & fifo_wr_di[34];
  assign frames_out = frames_q;

  // Admission checks apply only at frame start; mid-frame only full stalls.
  assign can_start = (frames_q < MAX_FRAMES) && !fifo_wr_almost_full;
  // A pop with nothing outstanding is spurious and dropped.
  assign pop_ok    = fifo_wr_eof_poped && (frames_q != 4'd0);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    frames_d     = frames_q;

    case (state_q)
      IDLE: begin
        if (can_start) begin
`ifdef TXLL_ARB_STRICT_PRIO_EN
          if (src0_valid)      state_d = GNT0;
          else if (src1_valid) state_d = GNT1;
`else
          if (src0_valid && src1_valid) state_d = last_grant_q ? GNT0 : GNT1;
          else if (src0_valid)          state_d = GNT0;
          else if (src1_valid)          state_d = GNT1;
`endif
        end
      end
      GNT0:    if (wr0 && src0_di[34]) state_d = IDLE;
      GNT1:    if (wr1 && src1_di[34]) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == IDLE && state_d == GNT0) last_grant_d = 1'b0;
    if (state_q == IDLE && state_d == GNT1) last_grant_d = 1'b1;

    case ({eof_wr, pop_ok})
      2'b10:   frames_d = frames_q + 4'd1;
      2'b01:   frames_d = frames_q - 4'd1;
      default: frames_d = frames_q;
    endcase
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;  // src0 wins the first tie after reset
      frames_q     <= 4'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      frames_q     <= frames_d;
    end
  end

endmodule

// File: doc/txll_arb.md
TXLL_ARB -- requirements
Module: txll_arb

Interface
REQ-001 Parameter C_MAX_FRAMES, default 8, maximum complete frames outstanding in the TX FIFO (range 1..15).
REQ-002 wr_clk  input  1  sole clock; every register samples on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 src0_di  input  36  requester 0 word; bit 34 = EOF, bits 35,33:0 passed unmodified.
REQ-005 src0_valid  input  1  requester 0 word valid.
REQ-006 src0_ready  output  1  requester 0 word accepted this cycle when high with src0_valid.
REQ-007 src1_di / src1_valid / src1_ready  input 36 / input 1 / output 1  requester 1, same semantics as requester 0.
REQ-008 fifo_wr_di  output  36  word to TX FIFO write port.
REQ-009 fifo_wr_en  output  1  TX FIFO write strobe.
REQ-010 fifo_wr_full  input  1  TX FIFO full.
REQ-011 fifo_wr_almost_full  input  1  TX FIFO almost full.
REQ-012 fifo_wr_eof_poped  input  1  single-cycle pulse per EOF word popped on the read side, already synchronised to wr_clk.
REQ-013 grant  output  2  one-hot current owner (bit0 = src0, bit1 = src1), 2'b00 when idle.
REQ-014 frames_out  output  4  complete frames written but not yet popped.

Function
REQ-015 FSM states IDLE, GNT0, GNT1; grant reflects the state combinationally.
REQ-016 IDLE -> GNTx on the clock edge where src x valid, frames_out < C_MAX_FRAMES and fifo_wr_almost_full low; otherwise stays IDLE.
REQ-017 Both valid in IDLE: without strict priority, grant the requester not granted last (round-robin, last_grant register).
REQ-018 In GNTx: srcx_ready = !fifo_wr_full; the other ready is 0; ready is 0 in IDLE.
REQ-019 fifo_wr_en = srcx_valid & srcx_ready of the granted source; fifo_wr_di = granted source's di; zero-cycle combinational latency; fifo_wr_di = 0 when no write.
REQ-020 Grant is frame-atomic: GNTx -> IDLE on the edge where a word with bit 34 = 1 is written; fifo_wr_almost_full and frame limit are ignored mid-frame, only fifo_wr_full stalls.
REQ-021 Consecutive frames therefore have exactly one idle cycle between EOF write and next first-word write.
REQ-022 frames_out +1 on EOF write, -1 on fifo_wr_eof_poped, unchanged when both occur in the same cycle.
REQ-023 fifo_wr_eof_poped with frames_out = 0 is ignored (no underflow); frames_out never exceeds C_MAX_FRAMES.
REQ-024 Single-word frame (first word carries EOF) is legal: GNTx for one accepted cycle, then IDLE.
REQ-025 A source dropping valid mid-frame keeps the grant; no timeout.

Reset
REQ-026 rst high: state IDLE, grant 0, frames_out 0, last_grant = src1 (so src0 wins first tie), both readies 0, fifo_wr_en 0.
REQ-027 rst mid-frame abandons the frame with no further write; the TX FIFO shares rst and is flushed by it.
REQ-028 Reset has priority over every simultaneous event, including a fifo_wr_eof_poped pulse.

Configuration
REQ-029 Macro TXLL_ARB_STRICT_PRIO_EN defined: in IDLE src0 always wins over src1; last_grant not used.
REQ-030 Macro undefined: round-robin per REQ-017; all other behaviour identical.

Verification
REQ-031 After reset, src0 4-word frame and src1 2-word frame both valid -> src0 words written first, 1 idle cycle, then src1; frames_out reaches 2.
REQ-032 Both sources stream continuous frames (round-robin build) -> grants alternate 0,1,0,1; with TXLL_ARB_STRICT_PRIO_EN only src0 granted.
REQ-033 C_MAX_FRAMES=2, three 1-word frames queued, no pops -> two written, grant stays 00; one fifo_wr_eof_poped pulse -> third frame written next cycles, frames_out back to 2.
REQ-034 fifo_wr_full asserted 3 cycles mid-frame -> ready 0 and no writes for those 3 cycles, no word lost or duplicated; almost_full mid-frame does not stall.
REQ-035 EOF write coincident with eof_poped pulse at frames_out=1 -> frames_out stays 1; pop at frames_out=0 -> stays 0.
REQ-036 rst pulse after 2 of 5 words of a src1 frame -> next cycle grant 00, frames_out 0, no writes until new request.
